scarv_cop: RTL and testbench



---
 rtl/scarv_cop_pkg.sv | 34 +++
 rtl/scarv_cop_if.sv | 39 +++
 rtl/scarv_cop_cprs.sv | 32 +++
 rtl/scarv_cop.sv | 214 +++++++++++++++++++++
 tb/tb_scarv_cop.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scarv_cop_pkg.sv
// Shared constants and types for the scarv_cop coprocessor: result codes,
// instruction encodings, ALU function selects and the control state enum.
package scarv_cop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MEM,
        ST_RSP
    } state_t;

    localparam logic [2:0] RES_SUCCESS    = 3'd0;
    localparam logic [2:0] RES_ABORT      = 3'd1;
    localparam logic [2:0] RES_BAD_INSN   = 3'd2;
    localparam logic [2:0] RES_BUS_ERROR  = 3'd3;
    localparam logic [2:0] RES_MISALIGNED = 3'd4;

    localparam logic [6:0] OPC_COP = 7'b0101011;

    localparam logic [2:0] F3_MV2GPR = 3'd0;
    localparam logic [2:0] F3_MV2COP = 3'd1;
    localparam logic [2:0] F3_ALU    = 3'd2;
    localparam logic [2:0] F3_LDW    = 3'd3;
    localparam logic [2:0] F3_STW    = 3'd4;

    localparam logic [6:0] F7_ADD  = 7'd0;
    localparam logic [6:0] F7_SUB  = 7'd1;
    localparam logic [6:0] F7_XOR  = 7'd2;
    localparam logic [6:0] F7_AND  = 7'd3;
    localparam logic [6:0] F7_OR   = 7'd4;
    localparam logic [6:0] F7_ROTL = 7'd5;
    localparam logic [6:0] F7_ROTR = 7'd6;

endpackage

// File: rtl/scarv_cop_if.sv
// CPU instruction/response handshake and memory word bus of scarv_cop.
// The slave modport is the coprocessor; master is the host CPU plus memory.
interface scarv_cop_if;

    logic        cpu_insn_req;
    logic        cop_insn_ack;
    logic        cpu_abort_req;
    logic [31:0] cpu_insn_enc;
    logic [31:0] cpu_rs1;
    logic        cop_wen;
    logic [4:0]  cop_waddr;
    logic [31:0] cop_wdata;
    logic [2:0]  cop_result;
    logic        cop_insn_rsp;
    logic        cpu_insn_ack;
    logic        cop_mem_cen;
    logic        cop_mem_wen;
    logic [31:0] cop_mem_addr;
    logic [31:0] cop_mem_wdata;
    logic [31:0] cop_mem_rdata;
    logic [3:0]  cop_mem_ben;
    logic        cop_mem_stall;
    logic        cop_mem_error;

    modport slave (
        input  cpu_insn_req, cpu_abort_req, cpu_insn_enc, cpu_rs1, cpu_insn_ack,
        input  cop_mem_rdata, cop_mem_stall, cop_mem_error,
        output cop_insn_ack, cop_wen, cop_waddr, cop_wdata, cop_result, cop_insn_rsp,
        output cop_mem_cen, cop_mem_wen, cop_mem_addr, cop_mem_wdata, cop_mem_ben
    );

    modport master (
        output cpu_insn_req, cpu_abort_req, cpu_insn_enc, cpu_rs1, cpu_insn_ack,
        output cop_mem_rdata, cop_mem_stall, cop_mem_error,
        input  cop_insn_ack, cop_wen, cop_waddr, cop_wdata, cop_result, cop_insn_rsp,
        input  cop_mem_cen, cop_mem_wen, cop_mem_addr, cop_mem_wdata, cop_mem_ben
    );

endinterface

// File: rtl/scarv_cop_cprs.sv
// 16 x 32-bit coprocessor register file: two asynchronous read ports,
// one synchronous write port, all entries cleared by reset.
module scarv_cop_cprs (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic [3:0]  rs1_addr,
    output logic [31:0] rs1_data,
    input  logic [3:0]  rs2_addr,
    output logic [31:0] rs2_data,
    input  logic        wen,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [16];

    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    // NOTE: a resettable array cannot map onto a RAM macro; it is built from
    // flops here because the register file must read as zero after reset.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (wen) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/scarv_cop.sv
// scarv_cop: single-issue cryptographic coprocessor core.
// Define SCARV_COP_ROT_EN to implement the ALU rotate functions (f7 = 5/6).
module scarv_cop
    import scarv_cop_pkg::*;
(
    input  logic       g_clk,
    input  logic       g_resetn,
    output logic       g_clk_req,
    scarv_cop_if.slave cop
);

    state_t      state_q, state_d;
    logic [31:0] enc_q, rs1_q;

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [3:0]  crd, crs1, crs2;
    logic [31:0] imm_i, imm_s, mem_addr_d;
    logic        is_ldw, is_stw, in_mem;

    logic [31:0] cpr_a, cpr_b;
    logic        cpr_we;
    logic [31:0] cpr_wdata;

    logic [31:0] alu_res;
    logic        alu_ok, insn_bad;

    logic        rsp_ld, mem_ld, rsp_wen_d;
    logic [2:0]  rsp_code;

    logic [31:0] mem_addr_q, mem_wdata_q;
    logic        mem_wen_q;

    logic [2:0]  result_q;
    logic        wen_q;
    logic [4:0]  waddr_q;
    logic [31:0] wdata_q;

    assign opc  = enc_q[6:0];
    assign rd   = enc_q[11:7];
    assign crd  = enc_q[10:7];
    assign f3   = enc_q[14:12];
    assign crs1 = enc_q[18:15];
    assign crs2 = enc_q[23:20];
    assign f7   = enc_q[31:25];

    assign imm_i = {{20{enc_q[31]}}, enc_q[31:20]};
    assign imm_s = {{20{enc_q[31]}}, enc_q[31:25], enc_q[11:7]};

    assign is_ldw     = (f3 == F3_LDW);
    assign is_stw     = (f3 == F3_STW);
    assign mem_addr_d = rs1_q + (is_stw ? imm_s : imm_i);

    scarv_cop_cprs u_cprs (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .rs1_addr (crs1),
        .rs1_data (cpr_a),
        .rs2_addr (crs2),
        .rs2_data (cpr_b),
        .wen      (cpr_we),
        .waddr    (crd),
        .wdata    (cpr_wdata)
    );

`ifdef SCARV_COP_ROT_EN
    logic [63:0] rot_l, rot_r;
    // Rotating a doubled word avoids a variable 32-n shift when n is zero.
    assign rot_l = {cpr_a, cpr_a} << cpr_b[4:0];
    assign rot_r = {cpr_a, cpr_a} >> cpr_b[4:0];
`endif

    // NOTE: every always_comb output gets a default first, so no path through
    // the case statements can leave a value unassigned and infer a latch.
    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b1;
        case (f7)
            F7_ADD:  alu_res = cpr_a + cpr_b;
            F7_SUB:  alu_res = cpr_a - cpr_b;
            F7_XOR:  alu_res = cpr_a ^ cpr_b;
            F7_AND:  alu_res = cpr_a & cpr_b;
            F7_OR:   alu_res = cpr_a | cpr_b;
`ifdef SCARV_COP_ROT_EN
            F7_ROTL: alu_res = rot_l[63:32];
            F7_ROTR: alu_res = rot_r[31:0];
`endif
            default: alu_ok  = 1'b0;
        endcase
    end

    assign insn_bad = (opc != OPC_COP) || (f3 > F3_STW) || ((f3 == F3_ALU) && !alu_ok);

    always_comb begin
        state_d   = state_q;
        cpr_we    = 1'b0;
        cpr_wdata = '0;
        rsp_ld    = 1'b0;
        mem_ld    = 1'b0;
        rsp_code  = RES_SUCCESS;
        unique case (state_q)
            ST_IDLE: begin
                if (cop.cpu_insn_req) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_RSP;
                rsp_ld  = 1'b1;
                if (cop.cpu_abort_req) begin
                    rsp_code = RES_ABORT;
                end else if (insn_bad) begin
                    rsp_code = RES_BAD_INSN;
                end else if (is_ldw || is_stw) begin
                    if (mem_addr_d[1:0] != 2'b00) begin
                        rsp_code = RES_MISALIGNED;
                    end else begin
                        state_d = ST_MEM;
                        rsp_ld  = 1'b0;
                        mem_ld  = 1'b1;
                    end
                end else if (f3 == F3_MV2COP) begin
                    cpr_we    = 1'b1;
                    cpr_wdata = rs1_q;
                end else if (f3 == F3_ALU) begin
                    cpr_we    = 1'b1;
                    cpr_wdata = alu_res;
                end
            end
            ST_MEM: begin
                // Abort is deliberately not looked at once the bus transfer is under way.
                if (!cop.cop_mem_stall) begin
                    state_d = ST_RSP;
                    rsp_ld  = 1'b1;
                    if (cop.cop_mem_error) begin
                        rsp_code = RES_BUS_ERROR;
                    end else if (is_ldw) begin
                        cpr_we    = 1'b1;
                        cpr_wdata = cop.cop_mem_rdata;
                    end
                end
            end
            ST_RSP: begin
                if (cop.cpu_insn_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_wen_d = (rsp_code == RES_SUCCESS) && (f3 == F3_MV2GPR);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            enc_q <= '0;
            rs1_q <= '0;
        end else if ((state_q == ST_IDLE) && cop.cpu_insn_req) begin
            enc_q <= cop.cpu_insn_enc;
            rs1_q <= cop.cpu_rs1;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wen_q   <= 1'b0;
        end else if (mem_ld) begin
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= is_stw ? cpr_b : '0;
            mem_wen_q   <= is_stw;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            result_q <= RES_SUCCESS;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else if (rsp_ld) begin
            result_q <= rsp_code;
            wen_q    <= rsp_wen_d;
            waddr_q  <= rd;
            wdata_q  <= rsp_wen_d ? cpr_a : '0;
        end
    end

    assign in_mem = (state_q == ST_MEM);

    assign g_clk_req        = (state_q != ST_IDLE) | cop.cpu_insn_req;
    assign cop.cop_insn_ack = (state_q == ST_IDLE);
    assign cop.cop_insn_rsp = (state_q == ST_RSP);
    assign cop.cop_result   = result_q;
    assign cop.cop_wen      = wen_q;
    assign cop.cop_waddr    = waddr_q;
    assign cop.cop_wdata    = wdata_q;

    // Bus outputs are held at zero outside the transfer so nothing leaks onto the bus.
    assign cop.cop_mem_cen   = in_mem;
    assign cop.cop_mem_wen   = in_mem & mem_wen_q;
    assign cop.cop_mem_addr  = in_mem ? mem_addr_q  : '0;
    assign cop.cop_mem_wdata = in_mem ? mem_wdata_q : '0;
    assign cop.cop_mem_ben   = (in_mem && mem_wen_q) ? 4'b1111 : 4'b0000;

endmodule

// File: tb/tb_scarv_cop.sv
// Self-checking bench for scarv_cop: directed cases from the test plan, then
// randomized instructions checked against a behavioural model of the CPRs.
module tb_scarv_cop;

    logic g_clk    = 1'b0;
    logic g_resetn = 1'b0;
    logic g_clk_req;

    scarv_cop_if bus ();

    scarv_cop dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .g_clk_req (g_clk_req),
        .cop       (bus)
    );

    always #5 g_clk = ~g_clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] cpr_m [16];

    bit          exp_valid = 1'b0;
    logic [2:0]  exp_result;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    bit          exp_bus;
    logic [31:0] exp_addr;
    logic        exp_mwen;
    logic [3:0]  exp_ben;
    logic [31:0] exp_mwdata;
    bit          cw_en;
    int          cw_idx;
    logic [31:0] cw_val;

    logic [2:0]  got_result;
    logic        got_wen;
    logic [4:0]  got_waddr;
    logic [31:0] got_wdata;
    logic [31:0] got_addr;
    logic        got_mwen;
    int          got_cen;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int s);
        if (s == 0) return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    // Reference behaviour of one instruction, computed from the field rules.
    task automatic predict(input logic [31:0] enc, input logic [31:0] rs1,
                           input bit abort, input bit err, input logic [31:0] rdata);
        logic [31:0] a, b, imm, addr;
        int f3, f7, crd, sh;
        bit bad;
        f3  = int'(enc[14:12]);
        f7  = int'(enc[31:25]);
        crd = int'(enc[10:7]);
        a   = cpr_m[enc[18:15]];
        b   = cpr_m[enc[23:20]];
        sh  = int'(b[4:0]);
        exp_waddr = enc[11:7];
        exp_wen = 1'b0; exp_wdata = '0; exp_bus = 1'b0; exp_addr = '0;
        exp_mwen = 1'b0; exp_ben = 4'h0; exp_mwdata = '0; cw_en = 1'b0;
        cw_idx = crd; cw_val = '0;
        exp_result = 3'd0;
        bad = (enc[6:0] != 7'h2B) || (f3 > 4);
        if (abort) begin
            exp_result = 3'd1;
        end else if (bad) begin
            exp_result = 3'd2;
        end else if (f3 == 0) begin
            exp_wen = 1'b1; exp_wdata = a;
        end else if (f3 == 1) begin
            cw_en = 1'b1; cw_val = rs1;
        end else if (f3 == 2) begin
            cw_en = 1'b1;
            case (f7)
                0: cw_val = a + b;
                1: cw_val = a - b;
                2: cw_val = a ^ b;
                3: cw_val = a & b;
                4: cw_val = a | b;
`ifdef SCARV_COP_ROT_EN
                5: cw_val = rotl32(a, sh);
                6: cw_val = rotl32(a, (32 - sh) % 32);
`endif
                default: begin cw_en = 1'b0; exp_result = 3'd2; end
            endcase
        end else begin
            if (f3 == 3) imm = {{20{enc[31]}}, enc[31:20]};
            else         imm = {{20{enc[31]}}, enc[31:25], enc[11:7]};
            addr = rs1 + imm;
            if (addr % 4 != 0) begin
                exp_result = 3'd4;
            end else begin
                exp_bus = 1'b1; exp_addr = addr;
                exp_mwen = (f3 == 4); exp_ben = (f3 == 4) ? 4'hF : 4'h0;
                exp_mwdata = b;
                exp_result = err ? 3'd3 : 3'd0;
                if (f3 == 3 && !err) begin cw_en = 1'b1; cw_val = rdata; end
            end
        end
        exp_valid = 1'b1;
    endtask

    // Single compare process: outputs are checked against the model on every
    // falling edge where a bus request or a response is presented.
    always @(negedge g_clk) begin
        if (g_resetn) begin
            if (bus.cop_mem_cen) begin
                check("mem_cen", bus.cop_mem_cen, exp_bus & exp_valid);
                check("mem_addr", bus.cop_mem_addr, exp_addr);
                check("mem_wen", bus.cop_mem_wen, exp_mwen);
                check("mem_ben", bus.cop_mem_ben, exp_ben);
                if (exp_mwen) check("mem_wdata", bus.cop_mem_wdata, exp_mwdata);
            end
            if (bus.cop_insn_rsp) begin
                check("rsp_valid", bus.cop_insn_rsp, exp_valid);
                check("result", bus.cop_result, exp_result);
                check("wen", bus.cop_wen, exp_wen);
                check("waddr", bus.cop_waddr, exp_waddr);
                check("wdata", bus.cop_wdata, exp_wdata);
                check("ack_busy", bus.cop_insn_ack, 1'b0);
                check("clk_req_busy", g_clk_req, 1'b1);
            end
        end
    end

    // Issue one instruction; called just after a rising edge with the core idle.
    task automatic run_insn(input logic [31:0] enc, input logic [31:0] rs1, input bit abort,
                            input int stalls, input bit err, input logic [31:0] rdata,
                            input int hold);
        int edges, st, exp_lat;
        logic [31:0] r;
        predict(enc, rs1, abort, err, rdata);
        check("ack_idle", bus.cop_insn_ack, 1'b1);
        bus.cpu_insn_enc = enc;
        bus.cpu_rs1      = rs1;
        bus.cpu_insn_req = 1'b1;
        @(posedge g_clk); #1;
        bus.cpu_insn_req  = 1'b0;
        bus.cpu_insn_enc  = $urandom;
        bus.cpu_rs1       = $urandom;
        bus.cpu_abort_req = abort;
        edges = 0; st = 0; got_cen = 0; got_addr = '0; got_mwen = 1'b0;
        for (int c = 0; c < 64 && !bus.cop_insn_rsp; c++) begin
            bus.cop_mem_stall = 1'b0;
            bus.cop_mem_error = 1'b0;
            if (bus.cop_mem_cen) begin
                if (got_cen == 0) begin got_addr = bus.cop_mem_addr; got_mwen = bus.cop_mem_wen; end
                got_cen++;
                r = $urandom;
                bus.cpu_abort_req = r[2];
                if (st < stalls) begin
                    st++;
                    bus.cop_mem_stall = 1'b1;
                    bus.cop_mem_error = r[0];
                    bus.cop_mem_rdata = $urandom;
                end else begin
                    bus.cop_mem_error = err;
                    bus.cop_mem_rdata = rdata;
                end
            end
            @(posedge g_clk); #1;
            edges++;
            bus.cpu_abort_req = 1'b0;
        end
        bus.cop_mem_stall = 1'b0;
        bus.cop_mem_error = 1'b0;
        bus.cpu_abort_req = 1'b0;
        exp_lat = exp_bus ? 2 + stalls : 1;
        check("rsp_arrived", bus.cop_insn_rsp, 1'b1);
        check("latency", edges, exp_lat);
        check("cen_cycles", got_cen, exp_bus ? stalls + 1 : 0);
        got_result = bus.cop_result;
        got_wen    = bus.cop_wen;
        got_waddr  = bus.cop_waddr;
        got_wdata  = bus.cop_wdata;
        for (int h = 0; h < hold; h++) begin
            @(posedge g_clk); #1;
            check("rsp_held", bus.cop_insn_rsp, 1'b1);
        end
        bus.cpu_insn_ack = 1'b1;
        @(posedge g_clk); #1;
        bus.cpu_insn_ack = 1'b0;
        check("idle_after_ack", bus.cop_insn_ack, 1'b1);
        check("rsp_dropped", bus.cop_insn_rsp, 1'b0);
        check("clk_req_idle", g_clk_req, 1'b0);
        exp_valid = 1'b0;
        if (cw_en) cpr_m[cw_idx] = cw_val;
    endtask

    task automatic gen_random(output logic [31:0] enc, output logic [31:0] rs1);
        int r;
        logic [31:0] t;
        logic [2:0] f3;
        enc = $urandom;
        rs1 = $urandom;
        t   = $urandom;
        r   = $urandom_range(0, 15);
        if (r <= 2)       f3 = 3'd0;
        else if (r <= 5)  f3 = 3'd1;
        else if (r <= 9)  f3 = 3'd2;
        else if (r <= 11) f3 = 3'd3;
        else if (r <= 13) f3 = 3'd4;
        else              f3 = 3'(t[7:6] == 2'b00 ? 3'd5 : {1'b1, t[7:6]});
        enc[14:12] = f3;
        enc[6:0]   = (r == 15) ? t[14:8] : 7'h2B;
        if (f3 == 3'd2) enc[31:25] = (t[2:0] == 3'd0) ? t[22:16] : 7'(t[5:3] % 7);
        if ((f3 == 3'd3 || f3 == 3'd4) && t[25:24] != 2'b00) begin
            rs1[1:0] = 2'b00; enc[21:20] = 2'b00; enc[8:7] = 2'b00;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got %0d failures", n_fail);
        $fatal(1);
    end

    initial begin
        logic [31:0] enc, rs1;
        bus.cpu_insn_req = 1'b0; bus.cpu_abort_req = 1'b0; bus.cpu_insn_enc = '0;
        bus.cpu_rs1 = '0; bus.cpu_insn_ack = 1'b0; bus.cop_mem_rdata = '0;
        bus.cop_mem_stall = 1'b0; bus.cop_mem_error = 1'b0;
        for (int i = 0; i < 16; i++) cpr_m[i] = '0;

        #3;
        check("rst_ack", bus.cop_insn_ack, 1'b1);
        check("rst_rsp", bus.cop_insn_rsp, 1'b0);
        check("rst_wen", bus.cop_wen, 1'b0);
        check("rst_waddr", bus.cop_waddr, 5'd0);
        check("rst_wdata", bus.cop_wdata, 32'd0);
        check("rst_result", bus.cop_result, 3'd0);
        check("rst_cen", bus.cop_mem_cen, 1'b0);
        check("rst_mwen", bus.cop_mem_wen, 1'b0);
        check("rst_addr", bus.cop_mem_addr, 32'd0);
        check("rst_mwdata", bus.cop_mem_wdata, 32'd0);
        check("rst_ben", bus.cop_mem_ben, 4'd0);
        check("rst_clk_req", g_clk_req, 1'b0);
        #9 g_resetn = 1'b1;
        @(posedge g_clk); #1;

        // Register round trip.
        run_insn(32'h000011AB, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        check("mv2cop_result", got_result, 3'd0);
        check("mv2cop_wen", got_wen, 1'b0);
        run_insn(32'h000182AB, 32'h0, 0, 0, 0, 0, 0);
        check("mv2gpr_result", got_result, 3'd0);
        check("mv2gpr_wen", got_wen, 1'b1);
        check("mv2gpr_waddr", got_waddr, 5'd5);
        check("mv2gpr_wdata", got_wdata, 32'hDEADBEEF);

        // ALU add with wrap.
        run_insn(32'h000011AB, 32'h80000001, 0, 0, 0, 0, 0);
        run_insn(32'h0031A22B, 32'h0, 0, 0, 0, 0, 0);
        run_insn(32'h0002022B, 32'h0, 0, 0, 0, 0, 0);
        check("add_wrap", got_wdata, 32'h00000002);

        // Load with three stall cycles.
        run_insn(32'h000030AB, 32'h00001000, 0, 3, 0, 32'h12345678, 0);
        check("ldw_result", got_result, 3'd0);
        check("ldw_addr", got_addr, 32'h00001000);
        check("ldw_mwen", got_mwen, 1'b0);
        check("ldw_cen_cycles", got_cen, 4);
        run_insn(32'h000080AB, 32'h0, 0, 0, 0, 0, 0);
        check("ldw_c1", got_wdata, 32'h12345678);

        // Misaligned and bus error.
        run_insn(32'h000030AB, 32'h00001002, 0, 0, 0, 32'h0, 0);
        check("misaligned_result", got_result, 3'd4);
        check("misaligned_no_cen", got_cen, 0);
        run_insn(32'h000030AB, 32'h00001000, 0, 1, 1, 32'hCAFEF00D, 0);
        check("buserr_result", got_result, 3'd3);
        run_insn(32'h000080AB, 32'h0, 0, 0, 0, 0, 0);
        check("buserr_c1_kept", got_wdata, 32'h12345678);

        // Bad instruction and abort.
        run_insn(32'h00000013, 32'h0, 0, 0, 0, 0, 0);
        check("bad_result", got_result, 3'd2);
        check("bad_wen", got_wen, 1'b0);
        run_insn(32'h000011AB, 32'h00000055, 1, 0, 0, 0, 0);
        check("abort_result", got_result, 3'd1);
        run_insn(32'h000181AB, 32'h0, 0, 0, 0, 0, 0);
        check("abort_c3_kept", got_wdata, 32'h80000001);

        // Store of c4 = 2 to 0x2000 + 8.
        run_insn(32'h0040442B, 32'h00002000, 0, 2, 0, 32'h0, 0);
        check("stw_addr", got_addr, 32'h00002008);
        check("stw_mwen", got_mwen, 1'b1);

        // Response held for five cycles without acknowledge.
        run_insn(32'h0002022B, 32'h0, 0, 0, 0, 0, 5);
        check("hold_wdata", got_wdata, 32'h00000002);

        // Reset during a stalled load.
        predict(32'h000030AB, 32'h00003000, 0, 0, 32'h0);
        bus.cpu_insn_enc = 32'h000030AB; bus.cpu_rs1 = 32'h00003000; bus.cpu_insn_req = 1'b1;
        @(posedge g_clk); #1;
        bus.cpu_insn_req = 1'b0; bus.cop_mem_stall = 1'b1;
        @(posedge g_clk); #1;
        @(posedge g_clk); #1;
        check("midrst_cen_before", bus.cop_mem_cen, 1'b1);
        exp_valid = 1'b0;
        g_resetn = 1'b0;
        #1;
        check("midrst_cen", bus.cop_mem_cen, 1'b0);
        check("midrst_ack", bus.cop_insn_ack, 1'b1);
        check("midrst_rsp", bus.cop_insn_rsp, 1'b0);
        #1 g_resetn = 1'b1;
        bus.cop_mem_stall = 1'b0;
        for (int i = 0; i < 16; i++) cpr_m[i] = '0;
        @(posedge g_clk); #1;
        run_insn(32'h000080AB, 32'h0, 0, 0, 0, 0, 0);
        check("midrst_c1_cleared", got_wdata, 32'h0);

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            gen_random(enc, rs1);
            run_insn(enc, rs1, ($urandom_range(0, 9) == 0), $urandom_range(0, 3),
                     ($urandom_range(0, 7) == 0), $urandom, $urandom_range(0, 2));
        end

        // Read every CPR back through MV2GPR.
        for (int i = 0; i < 16; i++) begin
            enc = 32'h0000002B;
            enc[18:15] = 4'(i);
            enc[11:7]  = 5'(i);
            run_insn(enc, 32'h0, 0, 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
